// File: rtl/fft_pkg.sv
// fft_pkg: shared types and elaboration-time helpers for the iterative FFT.
//   fft_state_e : LOAD -> COMPUTE -> OUTPUT frame sequencing
//   log2n_ok    : legal point-count range (LOG2N 2..6)
//   bitrev      : bit-reversed load address
//   tw_val      : twiddle W_N^k = cos(2pik/N) - j sin(2pik/N) in Q1.(tw-2), round to nearest
//   rnd_shr     : arithmetic right shift with round-half-up
//   sat_w       : clamp to a signed width, reporting whether clamping happened
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } fft_state_e;

  localparam int  LOG2N_MIN = 2;
  localparam int  LOG2N_MAX = 6;
  localparam real PI        = 3.14159265358979323846;

  function automatic bit log2n_ok(input int l);
    return (l >= LOG2N_MIN) && (l <= LOG2N_MAX);
  endfunction

  function automatic int bitrev(input int k, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // imag=0 gives the real part, imag=1 the (negative-sine) imaginary part.
  function automatic int tw_val(input int k, input int n, input int tw, input bit imag);
    real ang, s, v;
    ang = 2.0 * PI * real'(k) / real'(n);
    s   = real'(longint'(1) << (tw - 2));
    v   = imag ? -$sin(ang) * s : $cos(ang) * s;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w,
                                               output logic hit);
    logic signed [63:0] hi, lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    hit = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly.
//   t = B * W (W conjugated when inverse), rounded half-up >> (TW-2), saturated to DW
//   y0 = A + t, y1 = A - t, saturated to DW; ovf flags any clamp in this butterfly.
// Ports: inverse, a_re/a_im, b_re/b_im (DW), w_re/w_im (TW) in; y0_*/y1_* (DW), ovf out.
// Config macro FFT_STAGE_SCALE_EN: halve every output (round half-up) before saturation.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic                 inverse,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] y0_re,
  output logic signed [DW-1:0] y0_im,
  output logic signed [DW-1:0] y1_re,
  output logic signed [DW-1:0] y1_im,
  output logic                 ovf
);

  // 64-bit working width comfortably holds the DW+TW+1 bit product sums.
  logic signed [63:0] ar, ai, br, bi, wr, wi, p_re, p_im, t_re, t_im;
  logic signed [63:0] s0r, s0i, s1r, s1i;
  logic               h_tr, h_ti, h_0r, h_0i, h_1r, h_1i;

  always_comb begin
    ar   = 64'(a_re);
    ai   = 64'(a_im);
    br   = 64'(b_re);
    bi   = 64'(b_im);
    wr   = 64'(w_re);
    wi   = inverse ? -64'(w_im) : 64'(w_im);
    p_re = br * wr - bi * wi;
    p_im = br * wi + bi * wr;
    t_re = sat_w(rnd_shr(p_re, TW - 2), DW, h_tr);
    t_im = sat_w(rnd_shr(p_im, TW - 2), DW, h_ti);
    s0r  = ar + t_re;
    s0i  = ai + t_im;
    s1r  = ar - t_re;
    s1i  = ai - t_im;
`ifdef FFT_STAGE_SCALE_EN
    s0r  = rnd_shr(s0r, 1);
    s0i  = rnd_shr(s0i, 1);
    s1r  = rnd_shr(s1r, 1);
    s1i  = rnd_shr(s1i, 1);
`endif
    y0_re = DW'(sat_w(s0r, DW, h_0r));
    y0_im = DW'(sat_w(s0i, DW, h_0i));
    y1_re = DW'(sat_w(s1r, DW, h_1r));
    y1_im = DW'(sat_w(s1i, DW, h_1i));
    ovf   = h_tr | h_ti | h_0r | h_0i | h_1r | h_1i;
  end

endmodule

// File: rtl/fft_iter_stream.sv
// fft_iter_stream: N-point (N = 2**LOG2N) iterative radix-2 DIT FFT/IFFT, single buffer.
//   LOAD    : accept N samples (valid/ready), store at bit-reversed address.
//   COMPUTE : LOG2N*N/2 cycles, one in-place butterfly per cycle.
//   OUTPUT  : stream N bins in natural order (valid/ready), then back to LOAD.
// Ports: clk, rst_n (async low); inverse, in_valid/in_ready, in_re/in_im;
//   out_valid/out_ready, out_re/out_im, out_idx, out_last; busy; ovf (sticky per frame).
// Config macro FFT_STAGE_SCALE_EN (in fft_butterfly): per-stage 1/2 scaling, total gain 1/N.
module fft_iter_stream
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int DW    = 16,
  parameter int TW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inverse,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_re,
  input  logic signed [DW-1:0]    in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_re,
  output logic signed [DW-1:0]    out_im,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    ovf
);

  localparam int N  = 1 << LOG2N;
  localparam int NH = N / 2;
  localparam int SW = $clog2(LOG2N);

  if (!log2n_ok(LOG2N) || (TW < 3) || (DW + TW > 60)) begin : g_bad_cfg
    $error("fft_iter_stream: unsupported LOG2N/DW/TW");
  end

  // Twiddle ROM, evaluated at elaboration.
  logic signed [TW-1:0] rom_re [NH];
  logic signed [TW-1:0] rom_im [NH];
  for (genvar k = 0; k < NH; k++) begin : g_rom
    localparam int WR = tw_val(k, N, TW, 1'b0);
    localparam int WI = tw_val(k, N, TW, 1'b1);
    assign rom_re[k] = TW'(WR);
    assign rom_im[k] = TW'(WI);
  end

  fft_state_e           state;
  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic [LOG2N-1:0]     ld_cnt, ld_addr, top_a, bot_a, lo_mask, bf_ext;
  logic [LOG2N-2:0]     bf_cnt, tw_k;
  logic [SW-1:0]        stg;
  logic                 inv_q;
  logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
  logic                 bf_ovf;

  // Butterfly b of stage s pairs (top, top + 2**s); twiddle W_N^(pos * N / 2**(s+1)).
  always_comb begin
    ld_addr = LOG2N'(bitrev(int'(ld_cnt), LOG2N));
    lo_mask = LOG2N'((1 << stg) - 1);
    bf_ext  = {1'b0, bf_cnt};
    top_a   = ((bf_ext >> stg) << (int'(stg) + 1)) | (bf_ext & lo_mask);
    bot_a   = top_a | (LOG2N'(1) << stg);
    tw_k    = (LOG2N-1)'(int'(bf_ext & lo_mask) << (LOG2N - 1 - int'(stg)));
  end

  fft_butterfly #(.DW(DW), .TW(TW)) u_bfly (
    .inverse (inv_q),
    .a_re    (mem_re[top_a]),
    .a_im    (mem_im[top_a]),
    .b_re    (mem_re[bot_a]),
    .b_im    (mem_im[bot_a]),
    .w_re    (rom_re[tw_k]),
    .w_im    (rom_im[tw_k]),
    .y0_re   (y0_re),
    .y0_im   (y0_im),
    .y1_re   (y1_re),
    .y1_im   (y1_im),
    .ovf     (bf_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      inv_q     <= 1'b0;
      ld_cnt    <= '0;
      bf_cnt    <= '0;
      stg       <= '0;
      out_idx   <= '0;
      for (int i = 0; i < N; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mem_re[ld_addr] <= in_re;
            mem_im[ld_addr] <= in_im;
            if (ld_cnt == '0) begin
              ovf   <= 1'b0;
              inv_q <= inverse;
            end
            ld_cnt <= ld_cnt + 1'b1;  // wraps to 0 for the next frame
            if (ld_cnt == LOG2N'(N - 1)) begin
              state    <= ST_COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          mem_re[top_a] <= y0_re;
          mem_im[top_a] <= y0_im;
          mem_re[bot_a] <= y1_re;
          mem_im[bot_a] <= y1_im;
          if (bf_ovf) ovf <= 1'b1;
          bf_cnt <= bf_cnt + 1'b1;
          if (&bf_cnt) begin
            if (stg == SW'(LOG2N - 1)) begin
              stg       <= '0;
              state     <= ST_OUTPUT;
              out_valid <= 1'b1;
            end else begin
              stg <= stg + 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (out_idx == LOG2N'(N - 1)) begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Natural-order read: DIT with bit-reversed load leaves bin k at address k.
  assign out_re   = out_valid ? mem_re[out_idx] : '0;
  assign out_im   = out_valid ? mem_im[out_idx] : '0;
  assign out_last = out_valid && (out_idx == LOG2N'(N - 1));

endmodule

// File: tb/tb_fft_iter_stream.sv
`timescale 1ns/1ps
module tb_fft_iter_stream;
  localparam int  LOG2N = 3;
  localparam int  N     = 8;
  localparam int  DW    = 16;
  localparam int  TW    = 16;
  localparam real PI    = 3.14159265358979323846;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit  SCALED = 1'b1;
`else
  localparam bit  SCALED = 1'b0;
`endif
  localparam real GAIN     = SCALED ? 0.125 : 1.0;
  localparam int  RAMP_B0  = SCALED ? 896 : 7168;
  localparam int  RAMP_B4  = SCALED ? -128 : -1024;
  localparam int  RAMP_B1I = SCALED ? 309 : 2472;
  localparam real RAMP_TOL = SCALED ? 1.0 : 2.0;
  localparam real RND_TOL  = SCALED ? 2.0 : 3.0;
  localparam int  IMP_BIN  = SCALED ? 32 : 256;
  localparam int  IMP_X0   = SCALED ? 32 : 2048;
  localparam bit  SAT_OVF  = !SCALED;

  typedef int  ivec_t [N];
  typedef real rvec_t [N];

  logic clk = 1'b0, rst_n = 1'b0, inverse = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [DW-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, busy, ovf;
  logic signed [DW-1:0] out_re, out_im;
  logic [LOG2N-1:0] out_idx;

  int    n_checks = 0, n_fail = 0;
  ivec_t cap_re, cap_im;
  int    ord_err, last_err, stab_err, ovl_err;
  bit    tmo, ovf_first;

  always #5 clk = ~clk;

  fft_iter_stream #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  // Reference: direct DFT (inverse: +j kernel), times build gain.
  task automatic ref_dft(input ivec_t xr, input ivec_t xi, input bit inv,
                         output rvec_t yr, output rvec_t yi);
    real th;
    for (int k = 0; k < N; k++) begin
      yr[k] = 0.0; yi[k] = 0.0;
      for (int n = 0; n < N; n++) begin
        th = (inv ? 2.0 : -2.0) * PI * real'(n * k) / real'(N);
        yr[k] += real'(xr[n]) * $cos(th) - real'(xi[n]) * $sin(th);
        yi[k] += real'(xr[n]) * $sin(th) + real'(xi[n]) * $cos(th);
      end
      yr[k] *= GAIN; yi[k] *= GAIN;
    end
  endtask

  task automatic rand_vec(output ivec_t xr, output ivec_t xi);
    for (int k = 0; k < N; k++) begin
      xr[k] = int'($urandom_range(4000)) - 2000;
      xi[k] = int'($urandom_range(4000)) - 2000;
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accept.
  // inverse is flipped after beat 0 so only the first beat's value may matter.
  task automatic send_frame(input ivec_t xr, input ivec_t xi, input bit inv, input int gap_pct);
    int w;
    tmo = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_re    = DW'(xr[k]);
      in_im    = DW'(xi[k]);
      inverse  = (k == 0) ? inv : ~inv;
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) tmo = 1'b1;
      @(negedge clk);
      if (k == 0) ovf_first = ovf;
    end
    in_valid = 1'b0;
    inverse  = 1'b0;
  endtask

  // Collects N bins with random out_ready, tallying protocol errors.
  task automatic recv_frame(input int rdy_pct);
    int cnt, cyc;
    bit stalled;
    logic signed [DW-1:0] hr, hi;
    logic [LOG2N-1:0] hidx;
    ord_err = 0; last_err = 0; stab_err = 0; ovl_err = 0;
    cnt = 0; cyc = 0; stalled = 1'b0; hr = '0; hi = '0; hidx = '0;
    while (cnt < N && cyc < 2000) begin
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      if (in_ready === 1'b1 && out_valid === 1'b1) ovl_err++;
      if (out_valid === 1'b1) begin
        if (stalled && (out_re !== hr || out_im !== hi || out_idx !== hidx)) stab_err++;
        if (out_ready) begin
          if (out_idx !== LOG2N'(cnt)) ord_err++;
          if (out_last !== (cnt == N - 1)) last_err++;
          cap_re[cnt] = out_re;
          cap_im[cnt] = out_im;
          cnt++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; hr = out_re; hi = out_im; hidx = out_idx;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cnt < N) tmo = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy, ovf, out_last, out_idx, out_re, out_im} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b ovf=%b last=%b idx=%0d re=%0d im=%0d, want all 0",
               in_ready, out_valid, busy, ovf, out_last, out_idx, out_re, out_im);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_rdy: in_ready=%b, want 0", in_ready); end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_rise: in_ready=%b, want 1", in_ready); end
  endtask

  task automatic test_ramp();
    ivec_t xr, xi;
    rvec_t er, ei;
    int lat;
    for (int k = 0; k < N; k++) begin xr[k] = k * 256; xi[k] = 0; end
    ref_dft(xr, xi, 1'b0, er, ei);
    send_frame(xr, xi, 1'b0, 0);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL compute_flags: busy=%b in_ready=%b out_valid=%b, want 1 0 0", busy, in_ready, out_valid);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LOG2N * N / 2) begin n_fail++; $display("FAIL compute_latency: %0d cycles, want %0d", lat, LOG2N * N / 2); end
    recv_frame(100);
    n_checks++;
    if (tmo || ord_err != 0 || last_err != 0) begin
      n_fail++;
      $display("FAIL ramp_protocol: tmo=%b ord=%0d last=%0d, want 0 0 0", tmo, ord_err, last_err);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ramp_ovf: ovf=%b, want 0", ovf); end
    n_checks++;
    if (rabs(real'(cap_re[0] - RAMP_B0)) > RAMP_TOL || rabs(real'(cap_im[0])) > RAMP_TOL) begin
      n_fail++; $display("FAIL ramp_bin0: got (%0d,%0d) want (%0d,0)", cap_re[0], cap_im[0], RAMP_B0);
    end
    n_checks++;
    if (rabs(real'(cap_re[4] - RAMP_B4)) > RAMP_TOL || rabs(real'(cap_im[4])) > RAMP_TOL) begin
      n_fail++; $display("FAIL ramp_bin4: got (%0d,%0d) want (%0d,0)", cap_re[4], cap_im[4], RAMP_B4);
    end
    n_checks++;
    if (rabs(real'(cap_re[1] - RAMP_B4)) > RAMP_TOL || rabs(real'(cap_im[1] - RAMP_B1I)) > RAMP_TOL) begin
      n_fail++; $display("FAIL ramp_bin1: got (%0d,%0d) want (%0d,%0d)", cap_re[1], cap_im[1], RAMP_B4, RAMP_B1I);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (rabs(cap_re[k] - er[k]) > RAMP_TOL || rabs(cap_im[k] - ei[k]) > RAMP_TOL) begin
        n_fail++; $display("FAIL ramp_model_bin%0d: got (%0d,%0d) want (%.1f,%.1f)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_impulse_ifft();
    ivec_t xr, xi;
    for (int k = 0; k < N; k++) begin xr[k] = (k == 0) ? 256 : 0; xi[k] = 0; end
    send_frame(xr, xi, 1'b0, 20);
    recv_frame(70);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (cap_re[k] != IMP_BIN || cap_im[k] != 0) begin
        n_fail++; $display("FAIL impulse_bin%0d: got (%0d,%0d) want (%0d,0)", k, cap_re[k], cap_im[k], IMP_BIN);
      end
    end
    xr = cap_re; xi = cap_im;
    send_frame(xr, xi, 1'b1, 20);
    recv_frame(70);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (cap_re[k] != ((k == 0) ? IMP_X0 : 0) || cap_im[k] != 0) begin
        n_fail++; $display("FAIL ifft_x%0d: got (%0d,%0d) want (%0d,0)", k, cap_re[k], cap_im[k], (k == 0) ? IMP_X0 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    ivec_t xr, xi;
    rvec_t er, ei;
    for (int k = 0; k < N; k++) begin xr[k] = 32767; xi[k] = 32767; end
    send_frame(xr, xi, 1'b0, 0);
    recv_frame(100);
    n_checks++;
    if (cap_re[0] != 32767 || cap_im[0] != 32767) begin
      n_fail++; $display("FAIL sat_bin0: got (%0d,%0d) want (32767,32767)", cap_re[0], cap_im[0]);
    end
    n_checks++;
    if (cap_re[4] != 0 || cap_im[4] != 0) begin
      n_fail++; $display("FAIL sat_bin4: got (%0d,%0d) want (0,0)", cap_re[4], cap_im[4]);
    end
    n_checks++;
    if (ovf !== SAT_OVF) begin n_fail++; $display("FAIL sat_ovf: ovf=%b, want %b", ovf, SAT_OVF); end
    rand_vec(xr, xi);
    ref_dft(xr, xi, 1'b0, er, ei);
    send_frame(xr, xi, 1'b0, 0);
    n_checks++;
    if (ovf_first !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_first_beat: ovf=%b, want 0", ovf_first); end
    recv_frame(100);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (rabs(cap_re[k] - er[k]) > RND_TOL || rabs(cap_im[k] - ei[k]) > RND_TOL) begin
        n_fail++; $display("FAIL post_sat_bin%0d: got (%0d,%0d) want (%.1f,%.1f)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_random_backpressure();
    ivec_t xr, xi;
    rvec_t er, ei;
    bit inv;
    for (int f = 0; f < 4; f++) begin
      rand_vec(xr, xi);
      inv = 1'($urandom_range(1));
      ref_dft(xr, xi, inv, er, ei);
      send_frame(xr, xi, inv, 30);
      recv_frame(50);
      n_checks++;
      if (tmo || ord_err != 0 || last_err != 0 || stab_err != 0 || ovl_err != 0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_protocol_f%0d: tmo=%b ord=%0d last=%0d stab=%0d ovl=%0d ovf=%b, want all 0",
                 f, tmo, ord_err, last_err, stab_err, ovl_err, ovf);
      end
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (rabs(cap_re[k] - er[k]) > RND_TOL || rabs(cap_im[k] - ei[k]) > RND_TOL) begin
          n_fail++; $display("FAIL bp_f%0d_bin%0d inv=%b: got (%0d,%0d) want (%.1f,%.1f)", f, k, inv, cap_re[k], cap_im[k], er[k], ei[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ivec_t xr, xi;
    rvec_t er, ei;
    bit inv;
    for (int f = 0; f < 3; f++) begin
      rand_vec(xr, xi);
      inv = 1'(f);
      ref_dft(xr, xi, inv, er, ei);
      send_frame(xr, xi, inv, 0);
      recv_frame(100);
      n_checks++;
      if (tmo || ord_err != 0 || ovl_err != 0) begin
        n_fail++; $display("FAIL b2b_protocol_f%0d: tmo=%b ord=%0d ovl=%0d, want 0 0 0", f, tmo, ord_err, ovl_err);
      end
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (rabs(cap_re[k] - er[k]) > RND_TOL || rabs(cap_im[k] - ei[k]) > RND_TOL) begin
          n_fail++; $display("FAIL b2b_f%0d_bin%0d: got (%0d,%0d) want (%.1f,%.1f)", f, k, cap_re[k], cap_im[k], er[k], ei[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    ivec_t xr, xi;
    rvec_t er, ei;
    int seen;
    rand_vec(xr, xi);
    send_frame(xr, xi, 1'b0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, ovf, out_last, out_idx, out_re, out_im} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%b vld=%b busy=%b ovf=%b idx=%0d re=%0d, want all 0",
               in_ready, out_valid, busy, ovf, out_idx, out_re);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_rdy: in_ready=%b, want 1", in_ready); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) seen++; end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midreset_no_output: %0d active cycles, want 0", seen); end
    rand_vec(xr, xi);
    ref_dft(xr, xi, 1'b0, er, ei);
    send_frame(xr, xi, 1'b0, 10);
    recv_frame(80);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (rabs(cap_re[k] - er[k]) > RND_TOL || rabs(cap_im[k] - ei[k]) > RND_TOL) begin
        n_fail++; $display("FAIL midreset_bin%0d: got (%0d,%0d) want (%.1f,%.1f)", k, cap_re[k], cap_im[k], er[k], ei[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_impulse_ifft();
    test_saturation();
    test_random_backpressure();
    test_back_to_back();
    test_reset_mid_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
